// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM-stage load/store port: fixed wait states, then a
// single-cycle ack. Holds a 2**ADDR_W x 32-bit array with byte-lane write masking.
module data_ram_resp #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        busy_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          sel_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         mem_q [Depth];

  logic                latch;
  logic                use_in;
  logic                commit;
  logic                we_eff;
  logic [ADDR_W-1:0]   addr_eff;
  logic [3:0]          sel_eff;
  logic [31:0]         wdata_eff;
  logic                unused_addr;

  // Byte offset and bits above the array size are ignored; addresses alias.
  assign unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_ce_i) begin
          latch   = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? StWait : StAck;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAck;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, before the latch.
  assign use_in    = (state_q == StIdle);
  assign we_eff    = use_in ? mem_we_i : we_q;
  assign addr_eff  = use_in ? mem_addr_i[ADDR_W+1:2] : addr_q;
  assign sel_eff   = use_in ? mem_sel_i : sel_q;
  assign wdata_eff = use_in ? mem_data_i : wdata_q;
  assign commit    = rst && (state_d == StAck);

  always_comb begin
    rdata_d = rdata_q;
    if (commit && !we_eff) rdata_d = mem_q[addr_eff];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= 4'd0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (latch) begin
        we_q    <= mem_we_i;
        addr_q  <= mem_addr_i[ADDR_W+1:2];
        sel_q   <= mem_sel_i;
        wdata_q <= mem_data_i;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && we_eff) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_eff[i]) mem_q[addr_eff][8*i +: 8] <= wdata_eff[8*i +: 8];
      end
    end
  end

  assign mem_data_o = rdata_q;
  assign mem_ack_o  = (state_q == StAck);
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: one instance with two wait states, one with none.
module tb_data_ram_resp;

  logic        clk;
  logic        rst;
  logic        ce, ce0;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata0;
  logic        ack, ack0;
  logic        busy, busy0;

  int checks = 0;
  int errors = 0;

  data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (ce),
    .mem_we_i   (we),
    .mem_addr_i (addr),
    .mem_sel_i  (sel),
    .mem_data_i (wdata),
    .mem_data_o (rdata),
    .mem_ack_o  (ack),
    .busy_o     (busy)
  );

  data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (ce0),
    .mem_we_i   (we),
    .mem_addr_i (addr),
    .mem_sel_i  (sel),
    .mem_data_i (wdata),
    .mem_data_o (rdata0),
    .mem_ack_o  (ack0),
    .busy_o     (busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns the number of rising edges until ack is seen.
  task automatic xact(input bit fast, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output int lat);
    we = w; addr = a; sel = s; wdata = d;
    if (fast) ce0 = 1'b1; else ce = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
    end while (!(fast ? ack0 : ack) && lat < 20);
    ce = 1'b0; ce0 = 1'b0;
    if (lat >= 20) check("xact_timeout", 32'(lat), 32'd0);
  endtask

  int lat;
  int nack, first, second;

  initial begin
    // Reset held with a request pending
    rst = 1'b0; ce = 1'b1; ce0 = 1'b0;
    we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", rdata, 32'h0);
    rst = 1'b1;

    // First edge after release accepts; ack three cycles later
    xact(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat);
    check("wr_lat", 32'(lat), 32'd3);
    @(negedge clk);
    check("ack_pulse", 32'(ack), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    xact(1'b0, 1'b0, 32'h10, 4'h0, 32'h0, lat);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_full", rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Byte lanes
    xact(1'b0, 1'b1, 32'h10, 4'b0101, 32'h11223344, lat);
    check("wr_keeps_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);
    xact(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, lat);
    check("rd_lanes", rdata, 32'hDE22BE44);
    @(negedge clk);
    xact(1'b0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, lat);
    check("sel0_lat", 32'(lat), 32'd3);
    @(negedge clk);
    xact(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, lat);
    check("sel0_unchanged", rdata, 32'hDE22BE44);
    @(negedge clk);

    // Aliasing and ignored byte offset
    xact(1'b0, 1'b1, 32'h1003, 4'hF, 32'hA5A5A5A5, lat);
    @(negedge clk);
    xact(1'b0, 1'b0, 32'h0, 4'hF, 32'h0, lat);
    check("alias", rdata, 32'hA5A5A5A5);
    @(negedge clk);

    // Latched request, ce dropped mid-wait
    xact(1'b0, 1'b1, 32'h24, 4'hF, 32'h0BADF00D, lat);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'h12345678; ce = 1'b1;
    @(posedge clk); @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_ack", 32'(ack), 32'd0);
    addr = 32'h24; wdata = 32'hFFFFFFFF; ce = 1'b0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (ack) nack++;
    end
    check("abort_acks", 32'(nack), 32'd1);
    xact(1'b0, 1'b0, 32'h20, 4'hF, 32'h0, lat);
    check("latched_wr", rdata, 32'h12345678);
    @(negedge clk);
    xact(1'b0, 1'b0, 32'h24, 4'hF, 32'h0, lat);
    check("latched_other", rdata, 32'h0BADF00D);
    @(negedge clk);

    // ce held through ack starts a new request
    we = 1'b0; addr = 32'h20; ce = 1'b1;
    nack = 0; first = 0; second = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (ack) begin
        nack++;
        if (nack == 1) first = i;
        if (nack == 2) begin
          second = i;
          ce = 1'b0;
        end
      end
    end
    ce = 1'b0;
    check("b2b_acks", 32'(nack), 32'd2);
    check("b2b_first", 32'(first), 32'd3);
    check("b2b_gap", 32'(second - first), 32'd4);

    // Zero wait states
    xact(1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, lat);
    check("w0_wr_lat", 32'(lat), 32'd1);
    @(negedge clk);
    xact(1'b1, 1'b0, 32'h30, 4'hF, 32'h0, lat);
    check("w0_rd_lat", 32'(lat), 32'd1);
    check("w0_rd", rdata0, 32'hCAFEF00D);
    @(negedge clk);

    // Reset during the wait of a write loses the write
    we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'h55555555; ce = 1'b1;
    @(posedge clk); @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    ce = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    nack = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      if (ack) nack++;
    end
    check("rst_no_ack", 32'(nack), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    xact(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, lat);
    check("rst_lost_wr", rdata, 32'hDE22BE44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
